// File: rtl/rl_hdr_pkg.sv
// Shared types and constants for the RL02 sector header decoder and its CRC unit.
package rl_hdr_pkg;

    typedef enum logic [2:0] {
        HUNT  = 3'd0,
        SHIFT = 3'd1,
        CHECK = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } hdrState_t;

    localparam logic [15:0] CRC_POLY = 16'hA001;
    localparam int HDR_BITS = 48;
    localparam int CRC_BITS = 32;

    // Field positions inside the 48-bit header (first received bit at index 0)
    localparam int SECTOR_LSB = 0;
    localparam int SECTOR_MSB = 5;
    localparam int HEAD_BIT   = 6;
    localparam int CYL_LSB    = 7;
    localparam int CYL_MSB    = 15;
    localparam int CRC_LSB    = 32;
    localparam int CRC_MSB    = 47;

    // One step of the reflected CRC-16, fed LSB first.
    function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic din);
        logic [15:0] nxt;
        nxt = crc >> 1;
        if (crc[0] ^ din) begin
            nxt = nxt ^ CRC_POLY;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rl_crc16_serial.sv
// Bit-serial reflected CRC-16 accumulator; also reused by the data-field checker.
module rl_crc16_serial
    import rl_hdr_pkg::*;
#(
    parameter logic [15:0] CRC_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crcStep(crc, bit_in);
        end
    end

endmodule

// File: rtl/rl_header_decoder.sv
// Recovers the RL02 sector header from the decoded read stream, checks its CRC
// and times the begin-write strobe for the write-sync window.
module rl_header_decoder
    import rl_hdr_pkg::*;
#(
    parameter int          PREAMBLE_MIN   = 16,
    parameter int          WRITE_GAP_BITS = 32,
    parameter logic [15:0] CRC_INIT       = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       sector_pulse,
    input  logic       inhibit,
    output logic [5:0] sector_num,
    output logic [8:0] cyl_num,
    output logic       head_num,
    output logic       hdr_ready,
    output logic       hdr_crc_err,
    output logic       begin_write
);

    localparam int              GAP_W        = $clog2(WRITE_GAP_BITS + 1);
    localparam logic [7:0]      PREAMBLE_THR = 8'(PREAMBLE_MIN);
    localparam logic [5:0]      HDR_LAST     = 6'(HDR_BITS - 1);
    localparam logic [5:0]      CRC_LIMIT    = 6'(CRC_BITS);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(WRITE_GAP_BITS - 1);

    hdrState_t              state;
    logic [7:0]             zeroCnt;
    logic [5:0]             bitCnt;
    logic [GAP_W-1:0]       gapCnt;
    logic [HDR_BITS-1:0]    shiftReg;
    logic [15:0]            crc;
    logic                   writeFired;
    logic                   errFired;

    logic bitAccept;
    logic syncHit;
    logic crcClear;
    logic crcEn;

    // A sector pulse always wins over a coincident bit cell.
    assign bitAccept = bit_valid && !inhibit && !sector_pulse;
    assign syncHit   = bitAccept && bit_in && (zeroCnt >= PREAMBLE_THR);
    assign crcClear  = (state == HUNT) && syncHit;
    assign crcEn     = (state == SHIFT) && bitAccept && (bitCnt < CRC_LIMIT);

    rl_crc16_serial #(
        .CRC_INIT(CRC_INIT)
    ) crcUnit (
        .clk   (clk),
        .rst   (rst),
        .clear (crcClear),
        .en    (crcEn),
        .bit_in(bit_in),
        .crc   (crc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HUNT;
            zeroCnt     <= '0;
            bitCnt      <= '0;
            gapCnt      <= '0;
            shiftReg    <= '0;
            writeFired  <= 1'b0;
            errFired    <= 1'b0;
            sector_num  <= '0;
            cyl_num     <= '0;
            head_num    <= 1'b0;
            hdr_ready   <= 1'b0;
            hdr_crc_err <= 1'b0;
            begin_write <= 1'b0;
        end else begin
            hdr_crc_err <= 1'b0;
            begin_write <= 1'b0;
            if (sector_pulse) begin
                // Re-arm for the next sector; held fields become stale.
                state      <= HUNT;
                hdr_ready  <= 1'b0;
                zeroCnt    <= '0;
                bitCnt     <= '0;
                gapCnt     <= '0;
                writeFired <= 1'b0;
                errFired   <= 1'b0;
            end else begin
                case (state)
                    HUNT: begin
                        if (bitAccept) begin
                            if (!bit_in) begin
                                if (zeroCnt != 8'hFF) begin
                                    zeroCnt <= zeroCnt + 8'd1;
                                end
                            end else if (syncHit) begin
                                state   <= SHIFT;
                                bitCnt  <= '0;
                                zeroCnt <= '0;
                            end else begin
                                zeroCnt <= '0;
                            end
                        end
                    end
                    SHIFT: begin
                        if (inhibit) begin
                            state <= HUNT;
                        end else if (bitAccept) begin
                            shiftReg <= {bit_in, shiftReg[HDR_BITS-1:1]};
                            bitCnt   <= bitCnt + 6'd1;
                            if (bitCnt == HDR_LAST) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (shiftReg[CRC_MSB:CRC_LSB] == crc) begin
                            sector_num <= shiftReg[SECTOR_MSB:SECTOR_LSB];
                            head_num   <= shiftReg[HEAD_BIT];
                            cyl_num    <= shiftReg[CYL_MSB:CYL_LSB];
                            hdr_ready  <= 1'b1;
                            gapCnt     <= '0;
                            state      <= GAP;
                        end else begin
                            hdr_crc_err <= !errFired;
                            errFired    <= 1'b1;
                            zeroCnt     <= '0;
                            state       <= HUNT;
                        end
                    end
                    GAP: begin
                        if (inhibit) begin
                            state <= HUNT;
                        end else if (bitAccept) begin
                            gapCnt <= gapCnt + 1'b1;
                            if (gapCnt == GAP_LAST) begin
                                // Only one write window per sector, even after a re-lock.
                                begin_write <= !writeFired;
                                writeFired  <= 1'b1;
                                state       <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rl_header_decoder.sv
// Directed bench for the RL02 header decoder: lock, CRC error, sync threshold,
// sector-pulse re-arm, async reset and read-inhibit abort.
module tb_rl_header_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       sector_pulse = 1'b0;
    logic       inhibit = 1'b0;
    logic [5:0] sector_num;
    logic [8:0] cyl_num;
    logic       head_num;
    logic       hdr_ready;
    logic       hdr_crc_err;
    logic       begin_write;

    int nChecks  = 0;
    int nFail    = 0;
    int bwCount  = 0;
    int errCount = 0;

    logic [15:0] h1Crc;
    logic [15:0] h2Crc;
    logic [47:0] hdr1;
    logic [47:0] hdr1Bad;
    logic [47:0] hdr2;

    always #5 clk = ~clk;

    rl_header_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .sector_pulse(sector_pulse),
        .inhibit     (inhibit),
        .sector_num  (sector_num),
        .cyl_num     (cyl_num),
        .head_num    (head_num),
        .hdr_ready   (hdr_ready),
        .hdr_crc_err (hdr_crc_err),
        .begin_write (begin_write)
    );

    always @(negedge clk) begin
        if (begin_write) bwCount++;
        if (hdr_crc_err) errCount++;
    end

    // Reference reflected CRC-16 (poly 0xA001) over word1 then word2, LSB first.
    function automatic logic [15:0] modelCrc(input logic [15:0] w1, input logic [15:0] w2);
        logic [15:0] c;
        logic [31:0] d;
        logic        fb;
        c = 16'h0000;
        d = {w2, w1};
        for (int i = 0; i < 32; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-20s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic sendZeros(input int n);
        for (int i = 0; i < n; i++) sendBit(1'b0);
    endtask

    task automatic sendHdrBits(input logic [47:0] h, input int from, input int cnt);
        for (int i = from; i < from + cnt; i++) sendBit(h[i]);
    endtask

    task automatic sendHeader(input int nz, input logic [47:0] h);
        sendZeros(nz);
        sendBit(1'b1);
        sendHdrBits(h, 0, 48);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseSector();
        @(negedge clk);
        sector_pulse = 1'b1;
        @(negedge clk);
        sector_pulse = 1'b0;
    endtask

    task automatic checkFields(input logic [8:0] cyl, input logic hd, input logic [5:0] sec);
        check("cyl_num", 16'(cyl_num), 16'(cyl));
        check("head_num", 16'(head_num), 16'(hd));
        check("sector_num", 16'(sector_num), 16'(sec));
    endtask

    initial begin
        h1Crc   = modelCrc(16'hD2E7, 16'h0000);
        h2Crc   = modelCrc(16'h7995, 16'h1234);
        hdr1    = {h1Crc, 16'h0000, 16'hD2E7};
        hdr1Bad = {h1Crc ^ 16'h0001, 16'h0000, 16'hD2E7};
        hdr2    = {h2Crc, 16'h1234, 16'h7995};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 16'(hdr_ready), 16'h0);
        check("rst_sector", 16'(sector_num), 16'h0);
        check("rst_cyl", 16'(cyl_num), 16'h0);
        check("rst_head", 16'(head_num), 16'h0);
        check("rst_crc_err", 16'(hdr_crc_err), 16'h0);
        check("rst_begin_write", 16'(begin_write), 16'h0);
        @(negedge clk);
        rst = 1'b1;

        // Good header: two-edge latency, fields, begin_write after 32 gap bits
        sendHeader(16, hdr1);
        check("ready_one_edge", 16'(hdr_ready), 16'h0);
        settle();
        check("ready_two_edges", 16'(hdr_ready), 16'h1);
        checkFields(9'h1A5, 1'b1, 6'h27);
        sendZeros(31);
        settle();
        check("bw_after_31", 16'(bwCount), 16'd0);
        sendBit(1'b0);
        check("bw_pulse", 16'(begin_write), 16'h1);
        settle();
        check("bw_one_clk", 16'(begin_write), 16'h0);
        sendZeros(40);
        settle();
        check("bw_once_done", 16'(bwCount), 16'd1);
        check("no_err_good", 16'(errCount), 16'd0);

        // Bad CRC: error pulse, no ready, no write window
        pulseSector();
        settle();
        check("pulse_clr_ready", 16'(hdr_ready), 16'h0);
        sendHeader(16, hdr1Bad);
        settle();
        check("crc_err_pulse", 16'(hdr_crc_err), 16'h1);
        settle();
        check("crc_err_one_clk", 16'(hdr_crc_err), 16'h0);
        check("bad_ready", 16'(hdr_ready), 16'h0);
        sendZeros(40);
        settle();
        check("bad_no_bw", 16'(bwCount), 16'd1);
        check("bad_err_count", 16'(errCount), 16'd1);

        // Sync threshold: 15 zeros no lock, 16 zeros lock
        pulseSector();
        sendZeros(15);
        sendBit(1'b1);
        sendHdrBits(hdr2, 0, 48);
        settle();
        settle();
        check("short_pre_ready", 16'(hdr_ready), 16'h0);
        check("short_pre_err", 16'(errCount), 16'd1);
        sendHeader(16, hdr2);
        settle();
        check("lock16_ready", 16'(hdr_ready), 16'h1);
        checkFields(9'h0F3, 1'b0, 6'h15);

        // Inhibit in GAP aborts without a pulse; fields stay valid
        sendZeros(10);
        @(negedge clk);
        inhibit = 1'b1;
        sendZeros(2);
        inhibit = 1'b0;
        sendZeros(30);
        settle();
        check("gap_abort_ready", 16'(hdr_ready), 16'h1);
        check("gap_abort_no_bw", 16'(bwCount), 16'd1);

        // Inhibit during header bits 10-20 aborts SHIFT; fresh header decodes
        sendZeros(16);
        sendBit(1'b1);
        sendHdrBits(hdr1, 0, 9);
        @(negedge clk);
        inhibit = 1'b1;
        sendHdrBits(hdr1, 9, 11);
        inhibit = 1'b0;
        settle();
        check("inh_keep_ready", 16'(hdr_ready), 16'h1);
        sendHeader(16, hdr1);
        settle();
        check("inh_fresh_ready", 16'(hdr_ready), 16'h1);
        checkFields(9'h1A5, 1'b1, 6'h27);
        check("inh_no_err", 16'(errCount), 16'd1);
        sendZeros(32);
        settle();
        check("inh_bw", 16'(bwCount), 16'd2);

        // Sector pulse together with header bit 20
        pulseSector();
        sendZeros(16);
        sendBit(1'b1);
        sendHdrBits(hdr2, 0, 19);
        @(negedge clk);
        bit_in       = hdr2[19];
        bit_valid    = 1'b1;
        sector_pulse = 1'b1;
        @(negedge clk);
        bit_valid    = 1'b0;
        sector_pulse = 1'b0;
        sendHdrBits(hdr2, 20, 28);
        settle();
        settle();
        check("sp20_ready", 16'(hdr_ready), 16'h0);
        check("sp20_no_err", 16'(errCount), 16'd1);
        check("sp20_no_bw", 16'(bwCount), 16'd2);
        pulseSector();
        sendHeader(16, hdr2);
        settle();
        check("sp20_next_ready", 16'(hdr_ready), 16'h1);
        checkFields(9'h0F3, 1'b0, 6'h15);

        // Asynchronous reset in the middle of GAP
        sendZeros(10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_ready", 16'(hdr_ready), 16'h0);
        check("arst_cyl", 16'(cyl_num), 16'h0);
        check("arst_sector", 16'(sector_num), 16'h0);
        check("arst_bw", 16'(begin_write), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        pulseSector();
        sendHeader(16, hdr1);
        settle();
        check("post_rst_ready", 16'(hdr_ready), 16'h1);
        checkFields(9'h1A5, 1'b1, 6'h27);
        sendZeros(32);
        settle();
        check("post_rst_bw", 16'(bwCount), 16'd3);
        check("final_err", 16'(errCount), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
